// File: rtl/valve_cmd_multi.sv
// Timestamped part queue driving NUM_VALVES ejector valves with fixed travel delay and pulse width.
// Optional MULTIHOT_REJECT_EN: refuse decisions with more than one valve selected and flag reject.
module valve_cmd_multi #(
  parameter int NUM_VALVES   = 2,
  parameter int DELAY_CYCLES = 1000,
  parameter int PULSE_CYCLES = 20000,
  parameter int QUEUE_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          part_ready,
  input  logic [NUM_VALVES-1:0]         valve_decision,
  input  logic                          clr_status,
  output logic [NUM_VALVES-1:0]         valve_cmd,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          reject
);

  localparam int TS_W = $clog2(DELAY_CYCLES + 1) + 1;
  localparam int PCW  = $clog2(PULSE_CYCLES + 1);
  localparam int QW   = $clog2(QUEUE_DEPTH);
  localparam int CW   = QW + 1;
  localparam bit BYPASS = (DELAY_CYCLES == 1);
  localparam logic [TS_W-1:0] AGE_FIRE   = TS_W'(DELAY_CYCLES - 1);
  localparam logic [PCW-1:0]  PULSE_LOAD = PCW'(PULSE_CYCLES);
  localparam logic [CW-1:0]   DEPTH      = CW'(QUEUE_DEPTH);

  logic [TS_W-1:0]       r_ts;
  logic [NUM_VALVES-1:0] r_dec   [QUEUE_DEPTH];
  logic [TS_W-1:0]       r_stamp [QUEUE_DEPTH];
  logic [QW-1:0]         r_wr;
  logic [QW-1:0]         r_rd;
  logic [CW-1:0]         r_count;
  logic [PCW-1:0]        r_pcnt  [NUM_VALVES];
  logic                  r_ovf;

  logic [TS_W-1:0]       w_age;
  logic                  w_req;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_evt;
  logic                  w_fire;
  logic [NUM_VALVES-1:0] w_fire_dec;

`ifdef MULTIHOT_REJECT_EN
  logic w_multi;
  logic w_rej_evt;
  logic r_rej;
`endif

  always_comb begin
`ifdef MULTIHOT_REJECT_EN
    w_multi   = |(valve_decision & (valve_decision - 1'b1));
    w_req     = part_ready && (valve_decision != '0) && !w_multi;
    w_rej_evt = part_ready && w_multi;
`else
    w_req     = part_ready && (valve_decision != '0);
`endif
    // Head is always the oldest entry, so only its age needs checking
    w_age      = r_ts - r_stamp[r_rd];
    w_pop      = !BYPASS && (r_count != '0) && (w_age == AGE_FIRE);
    w_full     = (r_count == DEPTH);
    w_push     = !BYPASS && w_req && (!w_full || w_pop);
    w_ovf_evt  = w_req && w_full && !w_pop;
    // A one-cycle delay leaves no room to queue: fire straight from the strobe
    w_fire     = BYPASS ? w_req : w_pop;
    w_fire_dec = BYPASS ? valve_decision : r_dec[r_rd];
  end

  // Queue payload: no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dec[r_wr]   <= valve_decision;
      r_stamp[r_wr] <= r_ts;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts      <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      valve_cmd <= '0;
      for (int i = 0; i < NUM_VALVES; i++) r_pcnt[i] <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_evt)       r_ovf <= 1'b1;
      else if (clr_status) r_ovf <= 1'b0;
      // A fire on an open valve reloads its counter, extending the pulse
      for (int i = 0; i < NUM_VALVES; i++) begin
        if (w_fire && w_fire_dec[i])  r_pcnt[i] <= PULSE_LOAD;
        else if (r_pcnt[i] != '0)     r_pcnt[i] <= r_pcnt[i] - 1'b1;
        valve_cmd[i] <= (r_pcnt[i] != '0);
      end
    end
  end

`ifdef MULTIHOT_REJECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_rej <= 1'b0;
    else if (w_rej_evt)  r_rej <= 1'b1;
    else if (clr_status) r_rej <= 1'b0;
  end
  assign reject = r_rej;
`else
  assign reject = 1'b0;
`endif

  assign queue_count = r_count;
  assign overflow    = r_ovf;
  assign busy        = (r_count != '0) || (|valve_cmd);

endmodule

// File: tb/tb_valve_cmd_multi.sv
// Bench for valve_cmd_multi: directed scenarios plus random traffic against a part-list model.
module tb_valve_cmd_multi;
  localparam int NV = 2;
  localparam int D  = 10;
  localparam int P  = 5;
  localparam int Q  = 4;

  logic          clk;
  logic          rst;
  logic          part_ready;
  logic [NV-1:0] valve_decision;
  logic          clr_status;
  logic [NV-1:0] valve_cmd;
  logic [2:0]    queue_count;
  logic          busy;
  logic          overflow;
  logic          reject;

  valve_cmd_multi #(.NUM_VALVES(NV), .DELAY_CYCLES(D), .PULSE_CYCLES(P), .QUEUE_DEPTH(Q)) dut (
    .clk(clk), .rst(rst), .part_ready(part_ready), .valve_decision(valve_decision),
    .clr_status(clr_status), .valve_cmd(valve_cmd), .queue_count(queue_count),
    .busy(busy), .overflow(overflow), .reject(reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int e;
  int acc_e[$];
  logic [NV-1:0] acc_d[$];
  logic m_ovf;
  logic m_rej;

  // Parts accepted with strobe edge E0 sit in the queue after edges E0 .. E0+D-2
  function automatic int live_before(input int k);
    int n = 0;
    foreach (acc_e[i]) if (acc_e[i] >= k - D + 1 && acc_e[i] <= k - 1) n++;
    return n;
  endfunction

  function automatic bit pop_at(input int k);
    foreach (acc_e[i]) if (acc_e[i] == k - D + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_count(input int k);
    int n = 0;
    foreach (acc_e[i]) if (acc_e[i] >= k - D + 2 && acc_e[i] <= k) n++;
    return n;
  endfunction

  function automatic logic [NV-1:0] exp_valve(input int k);
    logic [NV-1:0] v = '0;
    foreach (acc_e[i]) if (k >= acc_e[i] + D && k <= acc_e[i] + D + P - 1) v = v | acc_d[i];
    return v;
  endfunction

  task automatic step(input logic pr, input logic [NV-1:0] dec, input logic clr);
    bit ovf_evt;
    bit rej_evt;
    ovf_evt = 1'b0;
    rej_evt = 1'b0;
    part_ready = pr;
    valve_decision = dec;
    clr_status = clr;
    e++;
    if (pr && dec != '0) begin
`ifdef MULTIHOT_REJECT_EN
      if ($countones(dec) > 1) rej_evt = 1'b1; else
`endif
      if (live_before(e) < Q || pop_at(e)) begin
        acc_e.push_back(e);
        acc_d.push_back(dec);
      end else ovf_evt = 1'b1;
    end
    m_ovf = ovf_evt ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_rej = rej_evt ? 1'b1 : (clr ? 1'b0 : m_rej);
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    acc_e.delete();
    acc_d.delete();
    m_ovf = 1'b0;
    m_rej = 1'b0;
    e = 0;
  endtask

  task automatic do_reset();
    part_ready = 1'b0;
    valve_decision = '0;
    clr_status = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (valve_cmd !== 2'b00) begin n_fail++; $display("FAIL reset.valve_cmd got %b exp 00", valve_cmd); end
    n_tests++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL reset.queue_count got %0d exp 0", queue_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy got %b exp 0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset.overflow got %b exp 0", overflow); end
    n_tests++; if (reject !== 1'b0) begin n_fail++; $display("FAIL reset.reject got %b exp 0", reject); end
  endtask

  task automatic test_single();
    int s, hi0, hi1, first;
    logic eb;
    hi0 = 0; hi1 = 0; first = -1;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      step(t == 0, (t == 0) ? 2'b01 : 2'b00, 1'b0);
      if (t == 0) s = e;
      eb = (exp_count(e) != 0) || (exp_valve(e) != '0);
      n_tests++; if (valve_cmd !== exp_valve(e)) begin n_fail++; $display("FAIL single.valve e=%0d got %b exp %b", e, valve_cmd, exp_valve(e)); end
      n_tests++; if (busy !== eb) begin n_fail++; $display("FAIL single.busy e=%0d got %b exp %b", e, busy, eb); end
      if (valve_cmd[0] === 1'b1) begin hi0++; if (first < 0) first = e - s; end
      if (valve_cmd[1] === 1'b1) hi1++;
    end
    n_tests++; if (first !== 10) begin n_fail++; $display("FAIL single.latency got %0d exp 10", first); end
    n_tests++; if (hi0 !== 5) begin n_fail++; $display("FAIL single.width got %0d exp 5", hi0); end
    n_tests++; if (hi1 !== 0) begin n_fail++; $display("FAIL single.valve1 got %0d exp 0", hi1); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single.busy_end got %b exp 0", busy); end
  endtask

  task automatic test_pipeline();
    int peak;
    logic [NV-1:0] d;
    peak = 0;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      d = (t == 0 || t == 6) ? 2'b01 : ((t == 3) ? 2'b10 : 2'b00);
      step(d != '0, d, 1'b0);
      n_tests++; if (valve_cmd !== exp_valve(e)) begin n_fail++; $display("FAIL pipe.valve e=%0d got %b exp %b", e, valve_cmd, exp_valve(e)); end
      n_tests++; if (queue_count !== 3'(exp_count(e))) begin n_fail++; $display("FAIL pipe.count e=%0d got %0d exp %0d", e, queue_count, exp_count(e)); end
      if (int'(queue_count) > peak) peak = int'(queue_count);
    end
    n_tests++; if (peak !== 3) begin n_fail++; $display("FAIL pipe.peak got %0d exp 3", peak); end
  endtask

  task automatic test_retrigger();
    int hi0;
    hi0 = 0;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      step(t == 0 || t == 2, (t == 0 || t == 2) ? 2'b01 : 2'b00, 1'b0);
      n_tests++; if (valve_cmd !== exp_valve(e)) begin n_fail++; $display("FAIL retrig.valve e=%0d got %b exp %b", e, valve_cmd, exp_valve(e)); end
      if (valve_cmd[0] === 1'b1) hi0++;
    end
    n_tests++; if (hi0 !== 7) begin n_fail++; $display("FAIL retrig.width got %0d exp 7", hi0); end
  endtask

  task automatic test_overflow();
    int hi1;
    hi1 = 0;
    do_reset();
    for (int t = 0; t < 32; t++) begin
      step(t <= 4, (t <= 4) ? 2'b10 : 2'b00, t == 30);
      n_tests++; if (valve_cmd !== exp_valve(e)) begin n_fail++; $display("FAIL ovf.valve e=%0d got %b exp %b", e, valve_cmd, exp_valve(e)); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf.flag e=%0d got %b exp %b", e, overflow, m_ovf); end
      if (t == 4) begin
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf.set got %b exp 1", overflow); end
        n_tests++; if (queue_count !== 3'd4) begin n_fail++; $display("FAIL ovf.full got %0d exp 4", queue_count); end
      end
      if (valve_cmd[1] === 1'b1) hi1++;
    end
    n_tests++; if (hi1 !== 8) begin n_fail++; $display("FAIL ovf.width got %0d exp 8", hi1); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf.clear got %b exp 0", overflow); end
  endtask

  task automatic test_zero_multihot();
    int hi0, hi1;
    hi0 = 0; hi1 = 0;
    do_reset();
    for (int t = 0; t < 35; t++) begin
      step(t == 0 || t == 15, (t == 15) ? 2'b11 : 2'b00, 1'b0);
      if (t == 0) begin
        n_tests++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL zero.count got %0d exp 0", queue_count); end
      end
      n_tests++; if (valve_cmd !== exp_valve(e)) begin n_fail++; $display("FAIL mh.valve e=%0d got %b exp %b", e, valve_cmd, exp_valve(e)); end
      n_tests++; if (reject !== m_rej) begin n_fail++; $display("FAIL mh.reject e=%0d got %b exp %b", e, reject, m_rej); end
      if (t < 15 && valve_cmd !== 2'b00) hi0 += 100;
      if (valve_cmd[0] === 1'b1) hi0++;
      if (valve_cmd[1] === 1'b1) hi1++;
    end
`ifdef MULTIHOT_REJECT_EN
    n_tests++; if (hi0 !== 0 || hi1 !== 0) begin n_fail++; $display("FAIL mh.pulses got %0d/%0d exp 0/0", hi0, hi1); end
    n_tests++; if (reject !== 1'b1) begin n_fail++; $display("FAIL mh.reject_end got %b exp 1", reject); end
`else
    n_tests++; if (hi0 !== 5 || hi1 !== 5) begin n_fail++; $display("FAIL mh.pulses got %0d/%0d exp 5/5", hi0, hi1); end
    n_tests++; if (reject !== 1'b0) begin n_fail++; $display("FAIL mh.reject_end got %b exp 0", reject); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [NV-1:0] d;
    do_reset();
    for (int t = 0; t <= 12; t++) begin
      d = (t == 0 || t == 8) ? 2'b01 : ((t == 5) ? 2'b10 : 2'b00);
      step(d != '0, d, 1'b0);
      n_tests++; if (valve_cmd !== exp_valve(e)) begin n_fail++; $display("FAIL rmid.pre e=%0d got %b exp %b", e, valve_cmd, exp_valve(e)); end
    end
    n_tests++; if (queue_count !== 3'd2) begin n_fail++; $display("FAIL rmid.pending got %0d exp 2", queue_count); end
    part_ready = 1'b0;
    valve_decision = '0;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (valve_cmd !== 2'b00) begin n_fail++; $display("FAIL rmid.async_valve got %b exp 00", valve_cmd); end
    n_tests++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL rmid.async_count got %0d exp 0", queue_count); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int t = 0; t < 30; t++) begin
      step(1'b0, 2'b00, 1'b0);
      n_tests++; if (valve_cmd !== 2'b00) begin n_fail++; $display("FAIL rmid.post e=%0d got %b exp 00", e, valve_cmd); end
    end
  endtask

  task automatic test_random();
    logic pr, clr, eb;
    logic [NV-1:0] d;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      pr  = ($urandom_range(0, 99) < 40);
      d   = NV'($urandom_range(0, 3));
      clr = ($urandom_range(0, 99) < 4);
      step(pr, d, clr);
      eb = (exp_count(e) != 0) || (exp_valve(e) != '0);
      n_tests++; if (valve_cmd !== exp_valve(e)) begin n_fail++; $display("FAIL rand.valve e=%0d got %b exp %b", e, valve_cmd, exp_valve(e)); end
      n_tests++; if (queue_count !== 3'(exp_count(e))) begin n_fail++; $display("FAIL rand.count e=%0d got %0d exp %0d", e, queue_count, exp_count(e)); end
      n_tests++; if (busy !== eb) begin n_fail++; $display("FAIL rand.busy e=%0d got %b exp %b", e, busy, eb); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand.overflow e=%0d got %b exp %b", e, overflow, m_ovf); end
      n_tests++; if (reject !== m_rej) begin n_fail++; $display("FAIL rand.reject e=%0d got %b exp %b", e, reject, m_rej); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    part_ready = 1'b0;
    valve_decision = '0;
    clr_status = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_pipeline();
    test_retrigger();
    test_overflow();
    test_zero_multihot();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
